mist_frame_monitor: RTL

- Simulation-side frame tracker that sits directly upstream of the waveform-dump control in the MiST test harness.
- Watches the game's vertical sync and produces the free-running frame counter that the dump control compares against its start frame.
- Also produces a dump-window enable, a sticky end-of-simulation request and a per-frame clock-cycle measurement, so the harness can gate dumping and stop the run without testbench-side counting.
- Synthesizable RTL; also instantiable in FPGA debug builds.

---
 rtl/mist_frame_monitor_if.sv | 24 ++
 rtl/mist_frame_monitor.sv | 114 +++++++++++
 2 files changed

// File: rtl/mist_frame_monitor_if.sv
// Frame monitor signal bundle: raw vertical sync in, frame tracking results out.
// Latency: none, wiring only.
// Backpressure: none; all signals are level/pulse outputs with no handshake.
interface mist_frame_monitor_if;
    logic        vs_in;
    logic        frame_strobe;
    logic [31:0] frame_cnt;
    logic        dump_en;
    logic        sim_done;
    logic [31:0] frame_len;
    logic        frame_len_valid;

    // Monitor side: consumes sync, drives the tracking results.
    modport master (
        input  vs_in,
        output frame_strobe, frame_cnt, dump_en, sim_done, frame_len, frame_len_valid
    );

    // Harness side: drives sync, consumes the tracking results.
    modport slave (
        output vs_in,
        input  frame_strobe, frame_cnt, dump_en, sim_done, frame_len, frame_len_valid
    );
endinterface

// File: rtl/mist_frame_monitor.sv
// Frame tracker: counts vsync frames, opens a dump window, requests end of run, measures frame period.
// Latency: frame_strobe/frame_cnt update 2 clk edges after the first edge that samples sync inactive.
// Backpressure: none; free-running observer, results are always valid to sample.
module mist_frame_monitor #(
    parameter int          VS_POL      = 1,
    parameter logic [31:0] DUMP_START  = 32'd0,
    parameter logic [31:0] DUMP_FRAMES = 32'd0,
    parameter logic [31:0] MAXFRAME    = 32'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    mist_frame_monitor_if.master mon
);

    // Inverting an active-low sync up front lets one falling-edge detector serve both polarities.
    localparam logic POL_INV = (VS_POL == 0) ? 1'b1 : 1'b0;

    logic        w_v;
    logic        w_fall;
    logic [31:0] w_cnt_inc;
    logic [31:0] w_wcnt_inc;
    logic        w_done_hit;

    logic        r_s1, r_s2, r_s3;
    logic        r_strobe;
    logic [31:0] r_frame_cnt;
    logic        r_dump_en;
    logic        r_win_used;
    logic [31:0] r_wcnt;
    logic        r_sim_done;
    logic [31:0] r_lc;
    logic [31:0] r_frame_len;
    logic        r_seen_fall;
    logic        r_len_vld;

    assign w_v        = mon.vs_in ^ POL_INV;
    // s1 is the metastability catcher; the edge is taken between s2 and s3.
    assign w_fall     = r_s3 & ~r_s2;
    assign w_cnt_inc  = r_frame_cnt + 32'd1;
    assign w_wcnt_inc = r_wcnt + 32'd1;
    assign w_done_hit = (MAXFRAME != 32'd0) && (w_cnt_inc == MAXFRAME);

    // Synchronise the asynchronous sync input into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= w_v;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Frame counting, one-shot dump window and sticky end-of-run; all frozen once sim_done is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe    <= 1'b0;
            r_frame_cnt <= 32'd0;
            r_dump_en   <= 1'b0;
            r_win_used  <= 1'b0;
            r_wcnt      <= 32'd0;
            r_sim_done  <= 1'b0;
        end else begin
            r_strobe <= w_fall;
            if (w_fall && !r_sim_done) begin
                r_frame_cnt <= w_cnt_inc;
                if (w_done_hit) begin
                    // Stopping the run takes priority and shuts the window in the same cycle.
                    r_sim_done <= 1'b1;
                    r_dump_en  <= 1'b0;
                end else if (!r_win_used && (r_frame_cnt == DUMP_START)) begin
                    // Compare against the pre-increment count to line up with the dump control.
                    r_dump_en  <= 1'b1;
                    r_win_used <= 1'b1;
                    r_wcnt     <= 32'd0;
                end else if (r_dump_en) begin
                    r_wcnt <= w_wcnt_inc;
                    if ((DUMP_FRAMES != 32'd0) && (w_wcnt_inc == DUMP_FRAMES)) begin
                        r_dump_en <= 1'b0;
                    end
                end
            end
        end
    end

    // Frame period measurement; the first capture after reset is partial and stays flagged invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lc        <= 32'd0;
            r_frame_len <= 32'd0;
            r_seen_fall <= 1'b0;
            r_len_vld   <= 1'b0;
        end else if (w_fall) begin
            r_frame_len <= r_lc;
            r_lc        <= 32'd1;
            r_seen_fall <= 1'b1;
            if (r_seen_fall) begin
                r_len_vld <= 1'b1;
            end
        end else if (r_lc != 32'hFFFF_FFFF) begin
            r_lc <= r_lc + 32'd1;
        end
    end

    assign mon.frame_strobe    = r_strobe;
    assign mon.frame_cnt       = r_frame_cnt;
    assign mon.dump_en         = r_dump_en;
    assign mon.sim_done        = r_sim_done;
    assign mon.frame_len       = r_frame_len;
    assign mon.frame_len_valid = r_len_vld;

endmodule
